// File: rtl/branch_target_table.sv
// Writable branch-target table: filled once per session over a valid/ready stream,
// read combinationally by branch index; unwritten entries read as zero.
module branch_target_table #(
    parameter int D = 12,
    parameter int A = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [A:0]          load_count,
    input  logic                in_valid,
    input  logic signed [D-1:0] in_target,
    output logic                in_ready,
    output logic                busy,
    output logic                done,
    output logic [A:0]          loaded_count,
    input  logic [A-1:0]        rd_addr,
    output logic signed [D-1:0] rd_target
);

    localparam int DEPTH = 1 << A;
    localparam logic [A:0] DEPTH_N = (A+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DEPTH-1:0]    valid;
    logic signed [D-1:0] data [DEPTH];
    logic [A:0]          cnt;
    logic [A:0]          len;
    logic [A:0]          len_in;
    logic [A-1:0]        wr_ptr;
    logic                start_ok;
    logic                accept;

    function automatic logic [A:0] sat_len(input logic [A:0] req);
        return (req > DEPTH_N) ? DEPTH_N : req;
    endfunction

    // Write pointer is the low part of the beat counter; the counter itself is the
    // reported loaded_count.
    assign wr_ptr       = cnt[A-1:0];
    assign len_in       = sat_len(load_count);
    assign start_ok     = start && (state != LOAD);
    assign accept       = in_valid && (state == LOAD);
    assign in_ready     = (state == LOAD);
    assign busy         = (state == LOAD);
    assign done         = (state == DONE);
    assign loaded_count = cnt;

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (len_in == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (accept && ((cnt + (A+1)'(1)) == len)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            valid <= '0;
            cnt   <= '0;
            len   <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                valid <= '0;
                cnt   <= '0;
                len   <= len_in;
            end else if (accept) begin
                valid[wr_ptr] <= 1'b1;
                cnt           <= cnt + (A+1)'(1);
            end
        end
    end

    // Payload storage carries no reset; the valid bits alone gate visibility.
    always_ff @(posedge clk) begin
        if (accept) begin
            data[wr_ptr] <= in_target;
        end
    end

    always_comb begin
        rd_target = valid[rd_addr] ? data[rd_addr] : '0;
    end

endmodule

// File: tb/tb_branch_target_table.sv
// Directed bench for branch_target_table: accepted beats go to a scoreboard queue
// and are checked against rd_target once the session completes.
module tb_branch_target_table;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  load_count;
    logic        in_valid;
    logic [11:0] in_target;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [5:0]  loaded_count;
    logic [4:0]  rd_addr;
    logic [11:0] rd_target;

    typedef struct {
        int          addr;
        logic [11:0] val;
    } ent_t;

    ent_t        sb[$];
    logic [11:0] vals[$];
    logic [11:0] model[32];
    bit          mvalid[32];
    int          vectors = 0;
    int          miscompares = 0;

    branch_target_table #(.D(12), .A(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_count(load_count),
        .in_valid(in_valid), .in_target(in_target), .in_ready(in_ready),
        .busy(busy), .done(done), .loaded_count(loaded_count),
        .rd_addr(rd_addr), .rd_target(rd_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 32; a++) begin
            rd_addr = a[4:0];
            @(negedge clk);
            check($sformatf("%s_addr%0d", tag, a), {20'd0, rd_target},
                  mvalid[a] ? {20'd0, model[a]} : 32'd0);
        end
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) begin
            ent_t e;
            e = sb.pop_front();
            rd_addr = e.addr[4:0];
            #1;
            check($sformatf("%s_sb%0d", tag, e.addr), {20'd0, rd_target}, {20'd0, e.val});
        end
    endtask

    // Runs one session from IDLE/DONE; gap toggles in_valid, start_beat re-asserts
    // start in the middle of LOAD (must be ignored).
    task automatic load_session(input string tag, input int n, input bit gap, input int start_beat);
        int len;
        int i;
        int cyc;
        len = (n > 32) ? 32 : n;
        @(negedge clk);
        start = 1'b1; load_count = n[5:0]; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        clear_model();
        if (len == 0) begin
            check({tag, "_done"}, done, 1);
            check({tag, "_busy"}, busy, 0);
            check({tag, "_ready"}, in_ready, 0);
            check({tag, "_cnt"}, loaded_count, 0);
            return;
        end
        rd_addr = 5'd7;
        #1;
        check({tag, "_old_cleared"}, rd_target, 0);
        check({tag, "_busy"}, busy, 1);
        i = 0; cyc = 0;
        while (i < len && cyc < 400) begin
            check($sformatf("%s_ready_c%0d", tag, cyc), in_ready, 1);
            check($sformatf("%s_cnt_c%0d", tag, cyc), loaded_count, i);
            in_valid   = gap ? (cyc % 2 == 0) : 1'b1;
            in_target  = vals[i];
            rd_addr    = i[4:0];
            start      = (i == start_beat);
            load_count = 6'd2;
            #1;
            check($sformatf("%s_prewrite%0d", tag, i), rd_target, 0);
            if (in_valid) begin
                sb.push_back('{i, vals[i]});
                model[i]  = vals[i];
                mvalid[i] = 1'b1;
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0;
        check({tag, "_beats"}, i, len);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_ready_end"}, in_ready, 0);
        check({tag, "_loaded"}, loaded_count, len);
        drain(tag);
        sweep(tag);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; load_count = '0; in_valid = 1'b0;
        in_target = '0; rd_addr = '0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", loaded_count, 0);
        sweep("rst");

        vals = '{12'd5, 12'd5, 12'd5, 12'd5, 12'd7, 12'd10, 12'd6, 12'd126,
                 12'd9, 12'd9, 12'd9, 12'd9, 12'hF14};
        load_session("full13", 13, 1'b0, -1);
        rd_addr = 5'd7;  #1; check("rd7", rd_target, 126);
        rd_addr = 5'd12; #1; check("rd12", rd_target, 12'hF14);
        rd_addr = 5'd13; #1; check("rd13", rd_target, 0);

        load_session("gap13", 13, 1'b1, -1);
        load_session("zero", 0, 1'b0, -1);
        sweep("zero");

        vals.delete();
        for (int k = 0; k < 32; k++) vals.push_back(12'((k * 37 + 3) ^ 12'h800));
        load_session("sat40", 40, 1'b0, -1);
        @(negedge clk);
        in_valid = 1'b1; in_target = 12'h555;
        #1;
        check("sat40_beat33_ready", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("sat40_loaded_hold", loaded_count, 32);
        check("sat40_done_hold", done, 1);

        vals = '{12'd5, 12'd5, 12'd5, 12'd5, 12'd7, 12'd10, 12'd6, 12'd126,
                 12'd9, 12'd9, 12'd9, 12'd9, 12'hF14};
        load_session("midstart", 13, 1'b0, 4);
        vals = '{12'd1, 12'd2};
        load_session("reload2", 2, 1'b0, -1);

        // Abort a session partway through with reset.
        vals = '{12'd5, 12'd5, 12'd5, 12'd5, 12'd7, 12'd10, 12'd6, 12'd126,
                 12'd9, 12'd9, 12'd9, 12'd9, 12'hF14};
        @(negedge clk);
        start = 1'b1; load_count = 6'd13;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_target = vals[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("abort_cnt6", loaded_count, 6);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_ready", in_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_cnt", loaded_count, 0);
        clear_model();
        sb.delete();
        sweep("abort");
        load_session("after_abort", 13, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
